// File: rtl/hp1349a_pkg.sv
// rtl/hp1349a_pkg.sv - shared opcode, field-position and width constants for the HP1349A command path
package hp1349a_pkg;
   localparam int COORD_W = 11;

   localparam logic [1:0] OP_PLOT  = 2'b00;
   localparam logic [1:0] OP_GRAPH = 2'b01;
   localparam logic [1:0] OP_TEXT  = 2'b10;
   localparam logic [1:0] OP_SETC  = 2'b11;

   localparam int OP_HI    = 14;
   localparam int OP_LO    = 13;
   localparam int AXIS_BIT = 12;
   localparam int PEN_BIT  = 11;
   localparam int FSEL_HI  = 12;
   localparam int FSEL_LO  = 11;

   localparam logic [1:0] FSEL_INTENSITY = 2'b00;
endpackage

// File: rtl/hp1349a_word_classify.sv
// rtl/hp1349a_word_classify.sv - combinational field extraction for one 15-bit bus word
module hp1349a_word_classify
   import hp1349a_pkg::*;
(
   input  logic [14:0]        word,
   output logic [1:0]         opcode,
   output logic               is_x,
   output logic               is_y,
   output logic               pen,
   output logic [COORD_W-1:0] coord,
   output logic [7:0]         char_code,
   output logic [1:0]         field,
   output logic [3:0]         value
);
   assign opcode    = word[OP_HI:OP_LO];
   assign is_x      = (opcode == OP_PLOT) && !word[AXIS_BIT];
   assign is_y      = (opcode == OP_PLOT) &&  word[AXIS_BIT];
   assign pen       = word[PEN_BIT];
   assign coord     = word[COORD_W-1:0];
   assign char_code = word[7:0];
   assign field     = word[FSEL_HI:FSEL_LO];
   assign value     = word[3:0];
endmodule

// File: rtl/hp1349a_cmd_decoder.sv
// rtl/hp1349a_cmd_decoder.sv - turns command FIFO words into vector segments and character events
module hp1349a_cmd_decoder #(
   parameter int               COORD_W       = 11,
   parameter logic [COORD_W-1:0] CHAR_PITCH  = 11'd24,
   parameter logic [3:0]       DEF_INTENSITY = 4'hF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               fifo_empty,
   output logic               fifo_read_en,
   input  logic [15:0]        fifo_read_data,
   output logic               vec_valid,
   input  logic               vec_ready,
   output logic [COORD_W-1:0] vec_x0,
   output logic [COORD_W-1:0] vec_y0,
   output logic [COORD_W-1:0] vec_x1,
   output logic [COORD_W-1:0] vec_y1,
   output logic [3:0]         vec_intensity,
   output logic               chr_valid,
   input  logic               chr_ready,
   output logic [7:0]         chr_code,
   output logic [COORD_W-1:0] chr_x,
   output logic [COORD_W-1:0] chr_y,
   output logic [7:0]         drop_cnt
);
   import hp1349a_pkg::*;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_VEC, S_CHR} state_t;

   state_t             state_q, state_d;
   logic               rd_en_q, rd_en_d;
   logic               vec_valid_q, vec_valid_d, chr_valid_q, chr_valid_d;
   logic [COORD_W-1:0] vec_x0_q, vec_x0_d, vec_y0_q, vec_y0_d;
   logic [COORD_W-1:0] vec_x1_q, vec_x1_d, vec_y1_q, vec_y1_d;
   logic [3:0]         vec_int_q, vec_int_d, intensity_q, intensity_d;
   logic [7:0]         chr_code_q, chr_code_d, drop_q, drop_d;
   logic [COORD_W-1:0] chr_x_q, chr_x_d, chr_y_q, chr_y_d;
   logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d, pend_x_q, pend_x_d;
   logic               have_x_q, have_x_d;

   logic [1:0]         w_op, w_field;
   logic               w_is_x, w_is_y, w_pen;
   logic [COORD_W-1:0] w_coord;
   logic [7:0]         w_char;
   logic [3:0]         w_value;
   logic               unused_bit15;

   assign unused_bit15 = fifo_read_data[15];

   hp1349a_word_classify u_classify (
      .word      (fifo_read_data[14:0]),
      .opcode    (w_op),
      .is_x      (w_is_x),
      .is_y      (w_is_y),
      .pen       (w_pen),
      .coord     (w_coord),
      .char_code (w_char),
      .field     (w_field),
      .value     (w_value)
   );

   // Extra carry bit catches a text advance running off the right edge.
   logic [COORD_W:0]   adv_x;
   logic [COORD_W-1:0] next_chr_x, sel_x;
   assign adv_x      = {1'b0, cur_x_q} + {1'b0, CHAR_PITCH};
   assign next_chr_x = adv_x[COORD_W] ? '1 : adv_x[COORD_W-1:0];
   assign sel_x      = have_x_q ? pend_x_q : cur_x_q;

   always_comb begin
      state_d     = state_q;
      rd_en_d     = 1'b0;
      vec_valid_d = vec_valid_q;
      vec_x0_d    = vec_x0_q;
      vec_y0_d    = vec_y0_q;
      vec_x1_d    = vec_x1_q;
      vec_y1_d    = vec_y1_q;
      vec_int_d   = vec_int_q;
      chr_valid_d = chr_valid_q;
      chr_code_d  = chr_code_q;
      chr_x_d     = chr_x_q;
      chr_y_d     = chr_y_q;
      cur_x_d     = cur_x_q;
      cur_y_d     = cur_y_q;
      pend_x_d    = pend_x_q;
      have_x_d    = have_x_q;
      intensity_d = intensity_q;
      drop_d      = drop_q;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               rd_en_d = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            state_d = S_IDLE;
            if (w_is_x) begin
               pend_x_d = w_coord;
               have_x_d = 1'b1;
            end else if (w_is_y && w_pen) begin
               vec_x0_d    = cur_x_q;
               vec_y0_d    = cur_y_q;
               vec_x1_d    = sel_x;
               vec_y1_d    = w_coord;
               vec_int_d   = intensity_q;
               vec_valid_d = 1'b1;
               state_d     = S_VEC;
            end else if (w_is_y) begin
               cur_x_d  = sel_x;
               cur_y_d  = w_coord;
               have_x_d = 1'b0;
            end else if (w_op == OP_TEXT) begin
               chr_code_d  = w_char;
               chr_x_d     = cur_x_q;
               chr_y_d     = cur_y_q;
               chr_valid_d = 1'b1;
               state_d     = S_CHR;
            end else if (w_op == OP_GRAPH) begin
               if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end else if (w_field == FSEL_INTENSITY) begin
               intensity_d = w_value;
            end
         end
         S_VEC: begin
            if (vec_ready) begin
               vec_valid_d = 1'b0;
               cur_x_d     = vec_x1_q;
               cur_y_d     = vec_y1_q;
               have_x_d    = 1'b0;
               state_d     = S_IDLE;
            end
         end
         S_CHR: begin
            if (chr_ready) begin
               chr_valid_d = 1'b0;
               cur_x_d     = next_chr_x;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rd_en_q     <= 1'b0;
         vec_valid_q <= 1'b0;
         vec_x0_q    <= '0;
         vec_y0_q    <= '0;
         vec_x1_q    <= '0;
         vec_y1_q    <= '0;
         vec_int_q   <= '0;
         chr_valid_q <= 1'b0;
         chr_code_q  <= '0;
         chr_x_q     <= '0;
         chr_y_q     <= '0;
         cur_x_q     <= '0;
         cur_y_q     <= '0;
         pend_x_q    <= '0;
         have_x_q    <= 1'b0;
         intensity_q <= DEF_INTENSITY;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         rd_en_q     <= rd_en_d;
         vec_valid_q <= vec_valid_d;
         vec_x0_q    <= vec_x0_d;
         vec_y0_q    <= vec_y0_d;
         vec_x1_q    <= vec_x1_d;
         vec_y1_q    <= vec_y1_d;
         vec_int_q   <= vec_int_d;
         chr_valid_q <= chr_valid_d;
         chr_code_q  <= chr_code_d;
         chr_x_q     <= chr_x_d;
         chr_y_q     <= chr_y_d;
         cur_x_q     <= cur_x_d;
         cur_y_q     <= cur_y_d;
         pend_x_q    <= pend_x_d;
         have_x_q    <= have_x_d;
         intensity_q <= intensity_d;
         drop_q      <= drop_d;
      end
   end

   assign fifo_read_en  = rd_en_q;
   assign vec_valid     = vec_valid_q;
   assign vec_x0        = vec_x0_q;
   assign vec_y0        = vec_y0_q;
   assign vec_x1        = vec_x1_q;
   assign vec_y1        = vec_y1_q;
   assign vec_intensity = vec_int_q;
   assign chr_valid     = chr_valid_q;
   assign chr_code      = chr_code_q;
   assign chr_x         = chr_x_q;
   assign chr_y         = chr_y_q;
   assign drop_cnt      = drop_q;
endmodule

// File: tb/tb_hp1349a_cmd_decoder.sv
// tb/tb_hp1349a_cmd_decoder.sv - scoreboard bench for the HP1349A command decoder
module tb_hp1349a_cmd_decoder;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fifo_empty, fifo_read_en;
   logic [15:0] fifo_read_data = 16'h0;
   logic        vec_valid, vec_ready = 1'b1;
   logic [10:0] vec_x0, vec_y0, vec_x1, vec_y1;
   logic [3:0]  vec_intensity;
   logic        chr_valid, chr_ready = 1'b1;
   logic [7:0]  chr_code;
   logic [10:0] chr_x, chr_y;
   logic [7:0]  drop_cnt;

   logic [15:0] fifo_q[$];
   logic [47:0] exp_vec[$];
   logic [29:0] exp_chr[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          rd_cnt = 0;

   assign fifo_empty = (fifo_q.size() == 0);

   hp1349a_cmd_decoder dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fifo_empty     (fifo_empty),
      .fifo_read_en   (fifo_read_en),
      .fifo_read_data (fifo_read_data),
      .vec_valid      (vec_valid),
      .vec_ready      (vec_ready),
      .vec_x0         (vec_x0),
      .vec_y0         (vec_y0),
      .vec_x1         (vec_x1),
      .vec_y1         (vec_y1),
      .vec_intensity  (vec_intensity),
      .chr_valid      (chr_valid),
      .chr_ready      (chr_ready),
      .chr_code       (chr_code),
      .chr_x          (chr_x),
      .chr_y          (chr_y),
      .drop_cnt       (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [47:0] seg(input int x0, input int y0, input int x1, input int y1,
                                       input int inten);
      return {x0[10:0], y0[10:0], x1[10:0], y1[10:0], inten[3:0]};
   endfunction

   function automatic logic [29:0] chv(input int code, input int x, input int y);
      return {code[7:0], x[10:0], y[10:0]};
   endfunction

   // FIFO model: word appears on fifo_read_data one cycle after the strobe.
   always @(negedge clk) begin
      if (rst_n && fifo_read_en && fifo_q.size() > 0) fifo_read_data = fifo_q.pop_front();
   end

   always @(negedge clk) begin
      if (rst_n && fifo_read_en) rd_cnt++;
      if (rst_n && vec_valid && vec_ready) begin
         if (exp_vec.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL vec_unexpected: got %0h expected none",
                     {vec_x0, vec_y0, vec_x1, vec_y1, vec_intensity});
         end else
            check("vec_seg", {vec_x0, vec_y0, vec_x1, vec_y1, vec_intensity}, exp_vec.pop_front());
      end
      if (rst_n && chr_valid && chr_ready) begin
         if (exp_chr.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL chr_unexpected: got %0h expected none", {chr_code, chr_x, chr_y});
         end else
            check("chr_event", {chr_code, chr_x, chr_y}, exp_chr.pop_front());
      end
   end

   task automatic push(input logic [15:0] w);
      fifo_q.push_back(w);
   endtask

   task automatic wait_quiet(input string name, input int budget);
      int n = 0;
      while (!(fifo_q.size() == 0 && exp_vec.size() == 0 && exp_chr.size() == 0 &&
               !vec_valid && !chr_valid) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(n < budget), 64'd1);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      int rd0;
      repeat (2) @(negedge clk);
      check("rst_rd_en", 64'(fifo_read_en), 64'd0);
      check("rst_vec_valid", 64'(vec_valid), 64'd0);
      check("rst_chr_valid", 64'(chr_valid), 64'd0);
      check("rst_coords", {vec_x0, vec_y0, vec_x1, vec_y1, chr_x}, 64'd0);
      check("rst_drop", 64'(drop_cnt), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Plain segment from origin, default intensity
      rd_cnt = 0;
      exp_vec.push_back(seg(0, 0, 100, 200, 15));
      push(16'h0064);
      push(16'h18C8);
      wait_quiet("t1_done", 200);
      check("t1_read_pulses", 64'(rd_cnt), 64'd2);

      // Intensity change, move, then Y-only draw
      exp_vec.push_back(seg(10, 20, 10, 300, 5));
      push(16'h6005);
      push(16'h000A);
      push(16'h1014);
      push(16'h192C);
      wait_quiet("t2_done", 300);

      // Character under backpressure; second word stays queued
      chr_ready = 1'b0;
      exp_chr.push_back(chv(8'h41, 10, 300));
      exp_chr.push_back(chv(8'h42, 34, 300));
      push(16'h4041);
      push(16'h4042);
      n = 0;
      while (!chr_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t3_chr_seen", 64'(chr_valid), 64'd1);
      rd0 = rd_cnt;
      repeat (20) begin
         @(negedge clk);
         check("t3_hold_valid", 64'(chr_valid), 64'd1);
         check("t3_hold_payload", {chr_code, chr_x, chr_y}, chv(8'h41, 10, 300));
      end
      check("t3_no_reads", 64'(rd_cnt), 64'(rd0));
      check("t3_queued", 64'(fifo_q.size()), 64'd1);
      chr_ready = 1'b1;
      wait_quiet("t3_done", 200);

      // Text advance saturating at the right edge
      exp_chr.push_back(chv(8'h43, 2040, 300));
      exp_chr.push_back(chv(8'h44, 2047, 300));
      push(16'h07F8);
      push(16'h112C);
      push(16'h4043);
      push(16'h4044);
      wait_quiet("t4_done", 300);

      // Discarded graph words
      for (int i = 0; i < 300; i++) push(16'h2000);
      wait_quiet("t5_done", 2000);
      check("t5_drop_sat", 64'(drop_cnt), 64'd255);

      // Reset while a segment is stalled
      vec_ready = 1'b0;
      push(16'h01F4);
      push(16'h1A58);
      n = 0;
      while (!vec_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t6_vec_seen", 64'(vec_valid), 64'd1);
      check("t6_vec_payload", {vec_x0, vec_y0, vec_x1, vec_y1, vec_intensity},
            seg(2047, 300, 500, 600, 5));
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_valid", 64'(vec_valid), 64'd0);
      check("t6_async_coords", {vec_x0, vec_y0, vec_x1, vec_y1, vec_intensity}, 64'd0);
      check("t6_async_drop", 64'(drop_cnt), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      vec_ready = 1'b1;
      exp_vec.push_back(seg(0, 0, 7, 9, 15));
      push(16'h0007);
      push(16'h1809);
      wait_quiet("t6_done", 200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
